// File: rtl/sha512_pkg.sv
// Shared constants and the state encoding for the SHA-512 message driver.
package sha512_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        PAD_EXTRA,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam int BLOCK_WORDS = 16;
    localparam int LEN_WORD_HI = 14;

    localparam logic [63:0] PAD_MARK = 64'h8000_0000_0000_0000;

    localparam logic [511:0] SHA512_IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [511:0] SHA512_T256_IV = {
        64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2,
        64'h2393b86b6f53b151, 64'h963877195940eabd,
        64'h96283ee2a88effe3, 64'hbe5e1e2553863992,
        64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2
    };

endpackage

// File: rtl/sha512_pad_word.sv
// Inserts the 0x80 terminator after the first nbytes bytes of a big-endian
// word and clears everything behind it; nbytes >= 8 passes the word through.
module sha512_pad_word (
    input  logic [63:0] word,
    input  logic [3:0]  nbytes,
    output logic [63:0] padded
);

    always_comb begin
        padded = word;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) == nbytes)
                padded[63-8*b -: 8] = 8'h80;
            else if (4'(b) > nbytes)
                padded[63-8*b -: 8] = 8'h00;
        end
    end

endmodule

// File: rtl/sha512_msg_driver.sv
// SHA-512 front end: collects 64-bit message words, pads, issues 1024-bit
// blocks to the compressor and chains the hash. SHA512_T256_EN adds SHA-512/256.
module sha512_msg_driver
    import sha512_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
`ifdef SHA512_T256_EN
    input  logic          mode_t256,
`endif
    output logic          comp_start,
    output logic [1023:0] comp_block,
    output logic [511:0]  comp_H_in,
    input  logic          comp_end,
    input  logic [511:0]  comp_H_out,
    output logic          digest_valid,
    output logic [511:0]  digest,
    output logic          busy
);

    state_t             state;
    logic [63:0]        blk [BLOCK_WORDS];
    logic [4:0]         word_idx;
    logic [LEN_W-1:0]   byte_cnt;
    logic [3:0]         last_bytes;
    logic               final_blk;
    logic               need_extra;
    logic               pad_pending;
`ifdef SHA512_T256_EN
    logic               t256;
`endif

    logic [3:0]         li;
    logic               last_partial;
    logic [4:0]         mark_pos;
    logic               pad_fits;
    logic [63:0]        pad_last;
    logic [127:0]       len_bits;
    logic [63:0]        pad_blk [BLOCK_WORDS];
    logic [511:0]       iv_sel;

    assign in_ready = !rst && ((state == IDLE) ||
                               (state == LOAD && word_idx < 5'(BLOCK_WORDS)));

    always_comb begin
        for (int i = 0; i < BLOCK_WORDS; i++)
            comp_block[1023-64*i -: 64] = blk[i];
    end

    // li wraps to 15 when all sixteen words have been written
    assign li           = 4'(word_idx - 5'd1);
    assign last_partial = (last_bytes < 4'd8);
    assign mark_pos     = last_partial ? {1'b0, li} : word_idx;
    assign pad_fits     = (mark_pos < 5'(LEN_WORD_HI));
    assign len_bits     = 128'(byte_cnt) << 3;

`ifdef SHA512_T256_EN
    assign iv_sel = mode_t256 ? SHA512_T256_IV : SHA512_IV;
`else
    assign iv_sel = SHA512_IV;
`endif

    sha512_pad_word u_pad_word (
        .word   (blk[li]),
        .nbytes (last_bytes),
        .padded (pad_last)
    );

    always_comb begin
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            pad_blk[i] = '0;
            if (5'(i) < {1'b0, li})
                pad_blk[i] = blk[i];
            else if (5'(i) == {1'b0, li})
                pad_blk[i] = pad_last;
            else if (!last_partial && 5'(i) == word_idx)
                pad_blk[i] = PAD_MARK;
            if (pad_fits && i == LEN_WORD_HI)
                pad_blk[i] = len_bits[127:64];
            if (pad_fits && i == LEN_WORD_HI + 1)
                pad_blk[i] = len_bits[63:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            for (int i = 0; i < BLOCK_WORDS; i++)
                blk[i] <= '0;
            comp_H_in    <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            comp_start   <= 1'b0;
            busy         <= 1'b0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            last_bytes   <= '0;
            final_blk    <= 1'b0;
            need_extra   <= 1'b0;
            pad_pending  <= 1'b0;
`ifdef SHA512_T256_EN
            t256         <= 1'b0;
`endif
        end else begin
            comp_start   <= 1'b0;
            digest_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        comp_H_in   <= iv_sel;
                        blk[0]      <= in_data;
                        word_idx    <= 5'd1;
                        byte_cnt    <= LEN_W'(in_last ? in_bytes : 4'd8);
                        last_bytes  <= in_bytes;
                        final_blk   <= 1'b0;
                        need_extra  <= 1'b0;
                        pad_pending <= 1'b0;
                        busy        <= 1'b1;
`ifdef SHA512_T256_EN
                        t256        <= mode_t256;
`endif
                        state       <= in_last ? PAD : LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid && word_idx < 5'(BLOCK_WORDS)) begin
                        blk[word_idx[3:0]] <= in_data;
                        word_idx   <= word_idx + 5'd1;
                        byte_cnt   <= byte_cnt + LEN_W'(in_last ? in_bytes : 4'd8);
                        last_bytes <= in_bytes;
                        if (in_last) begin
                            state <= PAD;
                        end else if (word_idx == 5'(BLOCK_WORDS - 1)) begin
                            state      <= ISSUE;
                            comp_start <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    for (int i = 0; i < BLOCK_WORDS; i++)
                        blk[i] <= pad_blk[i];
                    final_blk   <= pad_fits;
                    need_extra  <= !pad_fits;
                    // a full last word in slot 15 leaves no room for the marker
                    pad_pending <= !last_partial && word_idx == 5'(BLOCK_WORDS);
                    state       <= ISSUE;
                    comp_start  <= 1'b1;
                end
                PAD_EXTRA: begin
                    blk[0] <= pad_pending ? PAD_MARK : 64'd0;
                    for (int i = 1; i < LEN_WORD_HI; i++)
                        blk[i] <= '0;
                    blk[LEN_WORD_HI]     <= len_bits[127:64];
                    blk[LEN_WORD_HI + 1] <= len_bits[63:0];
                    final_blk  <= 1'b1;
                    need_extra <= 1'b0;
                    state      <= ISSUE;
                    comp_start <= 1'b1;
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (comp_end) begin
                        comp_H_in <= comp_H_out;
                        if (final_blk) begin
                            state <= DONE;
                        end else if (need_extra) begin
                            state <= PAD_EXTRA;
                        end else begin
                            word_idx <= '0;
                            state    <= LOAD;
                        end
                    end
                end
                DONE: begin
`ifdef SHA512_T256_EN
                    digest <= {comp_H_in[511:256], t256 ? 256'd0 : comp_H_in[255:0]};
`else
                    digest <= comp_H_in;
`endif
                    digest_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha512_msg_driver.sv
// Directed bench for sha512_msg_driver with a behavioural SHA-512 compressor.
module tb_sha512_msg_driver;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic [3:0]    in_bytes = '0;
`ifdef SHA512_T256_EN
    logic          mode_t256 = 1'b0;
`endif
    logic          comp_start;
    logic [1023:0] comp_block;
    logic [511:0]  comp_H_in;
    logic          comp_end;
    logic [511:0]  comp_H_out;
    logic          digest_valid;
    logic [511:0]  digest;
    logic          busy;

    sha512_msg_driver #(.LEN_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
`ifdef SHA512_T256_EN
        .mode_t256    (mode_t256),
`endif
        .comp_start   (comp_start),
        .comp_block   (comp_block),
        .comp_H_in    (comp_H_in),
        .comp_end     (comp_end),
        .comp_H_out   (comp_H_out),
        .digest_valid (digest_valid),
        .digest       (digest),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [511:0] sha_compress(input logic [511:0] hin, input logic [1023:0] b);
        logic [63:0] w [80];
        logic [63:0] hv [8];
        logic [63:0] a, bb, c, d, e, f, g, h, t1, t2;
        logic [511:0] r;
        for (int i = 0; i < 8; i++) hv[i] = hin[511-64*i -: 64];
        for (int i = 0; i < 16; i++) w[i] = b[1023-64*i -: 64];
        for (int i = 16; i < 80; i++)
            w[i] = (rotr(w[i-2], 19) ^ rotr(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7] +
                   (rotr(w[i-15], 1) ^ rotr(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
        a = hv[0]; bb = hv[1]; c = hv[2]; d = hv[3];
        e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
        for (int i = 0; i < 80; i++) begin
            t1 = h + (rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39)) + ((a & bb) ^ (a & c) ^ (bb & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = bb; bb = a; a = t1 + t2;
        end
        hv[0] += a; hv[1] += bb; hv[2] += c; hv[3] += d;
        hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
        for (int i = 0; i < 8; i++) r[511-64*i -: 64] = hv[i];
        return r;
    endfunction

    // Compressor model: answers each comp_start with comp_end three cycles later.
    int            n_starts = 0;
    int            end_cyc = 0;
    logic [1023:0] last_blk = '0;

    initial begin
        int pend;
        logic [511:0] res;
        pend = 0;
        res = '0;
        comp_end = 1'b0;
        comp_H_out = '0;
        forever begin
            @(negedge clk);
            comp_end = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        comp_end = 1'b1;
                        comp_H_out = res;
                        end_cyc = cyc;
                    end
                end
                if (comp_start) begin
                    last_blk = comp_block;
                    n_starts++;
                    res = sha_compress(comp_H_in, comp_block);
                    pend = 3;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string         name;
        int            nbytes;
        bit            literal;
        logic [1023:0] lit;
        int            exp_blocks;
        bit            chk_dig;
        logic [511:0]  exp_dig;
        logic [63:0]   fin_w0;
        logic [63:0]   fin_w15;
        bit            mid_zero;
    } vec_t;

    vec_t vecs[8];
    int   nv = 0;
    logic [7:0] mbuf [256];

    localparam logic [511:0] DIG_ABC =
        512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    localparam logic [511:0] DIG_EMPTY =
        512'hcf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e;
    localparam logic [511:0] DIG_896 =
        512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;

    task automatic add_vec(input string nm, input int n, input bit is_lit, input logic [1023:0] l,
                           input int blks, input bit cd, input logic [511:0] dg,
                           input logic [63:0] w0, input logic [63:0] w15, input bit mz);
        vecs[nv].name = nm;       vecs[nv].nbytes = n;
        vecs[nv].literal = is_lit; vecs[nv].lit = l;
        vecs[nv].exp_blocks = blks; vecs[nv].chk_dig = cd;
        vecs[nv].exp_dig = dg;    vecs[nv].fin_w0 = w0;
        vecs[nv].fin_w15 = w15;   vecs[nv].mid_zero = mz;
        nv++;
    endtask

    task automatic build_msg(input int v);
        logic [1023:0] l;
        l = vecs[v].lit;
        for (int i = 0; i < vecs[v].nbytes; i++)
            mbuf[i] = vecs[v].literal ? l[(vecs[v].nbytes-1-i)*8 +: 8] : 8'(i);
    endtask

    task automatic feed(input string nm, input int n);
        int nw;
        int t;
        logic [63:0] w;
        nw = (n == 0) ? 1 : (n + 7) / 8;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int b = 0; b < 8; b++)
                if (8*k + b < n) w[63-8*b -: 8] = mbuf[8*k + b];
            in_data  = w;
            in_last  = (k == nw - 1);
            in_bytes = (k == nw - 1) ? 4'(n - 8*k) : 4'd0;
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 1000) begin
                chk({nm, " in_ready timeout"}, in_ready, 1);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_dv(input string nm, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (digest_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({nm, " digest_valid timeout"}, ok, 1);
    endtask

    task automatic run_vec(input int v);
        int s0;
        int dvc;
        bit ok;
        s0 = n_starts;
        build_msg(v);
        feed(vecs[v].name, vecs[v].nbytes);
        wait_dv(vecs[v].name, ok);
        dvc = cyc;
        if (ok) begin
            chk({vecs[v].name, " blocks"}, n_starts - s0, vecs[v].exp_blocks);
            chk({vecs[v].name, " latency"}, dvc - end_cyc, 2);
            chk({vecs[v].name, " busy"}, busy, 0);
            chk({vecs[v].name, " fin w0"}, last_blk[1023:960], vecs[v].fin_w0);
            chk({vecs[v].name, " fin w14"}, last_blk[127:64], 0);
            chk({vecs[v].name, " fin w15"}, last_blk[63:0], vecs[v].fin_w15);
            if (vecs[v].mid_zero)
                chk({vecs[v].name, " fin w1..13"}, last_blk[959:128], 0);
            if (vecs[v].chk_dig)
                chk({vecs[v].name, " digest"}, digest, vecs[v].exp_dig);
            @(negedge clk);
            chk({vecs[v].name, " dv pulse"}, digest_valid, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int bad;
        int t;
        bit ok;

        add_vec("abc",   3,   1, 1024'("abc"), 1, 1, DIG_ABC,   64'h6162638000000000, 64'h18,  1);
        add_vec("empty", 0,   1, '0,           1, 1, DIG_EMPTY, 64'h8000000000000000, 64'h0,   1);
        add_vec("m112",  112, 1,
                1024'("abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu"),
                2, 1, DIG_896, 64'h0, 64'h380, 1);
        add_vec("m128",  128, 0, '0, 2, 0, '0, 64'h8000000000000000, 64'h400, 1);
        add_vec("m136",  136, 0, '0, 2, 0, '0, 64'h8081828384858687, 64'h440, 0);
        add_vec("m111",  111, 0, '0, 1, 0, '0, 64'h0001020304050607, 64'h378, 0);
        add_vec("m120",  120, 0, '0, 2, 0, '0, 64'h0,                64'h3c0, 1);
        add_vec("m125",  125, 0, '0, 2, 0, '0, 64'h0,                64'h3e8, 1);

        repeat (3) @(negedge clk);
        chk("reset in_ready", in_ready, 0);
        chk("reset comp_block", comp_block[511:0] | comp_block[1023:512], 0);
        chk("reset comp_H_in", comp_H_in, 0);
        chk("reset digest", digest, 0);
        chk("reset flags", {comp_start, digest_valid, busy}, 0);
        rst = 1'b0;
        #1;
        chk("idle in_ready", in_ready, 1);
        @(negedge clk);

        for (int v = 0; v < nv; v++)
            run_vec(v);

        // Next message word held valid while the previous one is still hashing.
        build_msg(0);
        s0 = n_starts;
        feed("bp", 3);
        in_data  = 64'h6162630000000000;
        in_last  = 1'b1;
        in_bytes = 4'd3;
        in_valid = 1'b1;
        bad = 0;
        ok = 1'b0;
        for (t = 0; t < 400; t++) begin
            if (in_ready) bad++;
            @(negedge clk);
            if (digest_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp first done", ok, 1);
        chk("bp in_ready low", bad, 0);
        chk("bp first digest", digest, DIG_ABC);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_dv("bp second", ok);
        chk("bp second digest", digest, DIG_ABC);
        chk("bp blocks", n_starts - s0, 2);
        @(negedge clk);

        // Abort while the compressor is working on the block.
        build_msg(0);
        s0 = n_starts;
        feed("rst", 3);
        t = 0;
        while (n_starts == s0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst reached issue", n_starts - s0, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst mid comp_block", comp_block[511:0] | comp_block[1023:512], 0);
        chk("rst mid comp_H_in", comp_H_in, 0);
        chk("rst mid digest", digest, 0);
        chk("rst mid flags", {comp_start, digest_valid, busy, in_ready}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sha512_msg_driver.md
Name: sha512_msg_driver

Overview:
Front end that feeds the SHA-512 compression core. It accepts a byte-aligned message as a 64-bit word stream and applies FIPS 180-4 padding (0x80 byte, zero fill, 128-bit big-endian bit length). It issues one 1024-bit block at a time to the compressor through a start/end handshake, chains the intermediate hash, and presents the final 512-bit digest. The Ed25519 datapath uses it for all SHA-512 hashing.

Parameters:
LEN_W, 64, width of the internal message byte counter. The bit length is zero-extended into the 128-bit length field.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  driver can accept a word
in_data  in  64  message word, big-endian (first byte in [63:56])
in_last  in  1  final word of the message
in_bytes  in  4  valid bytes in the last word (0..8), left-aligned; ignored unless in_last
comp_start  out  1  one-cycle pulse to the compressor
comp_block  out  1024  block; word 0 in [1023:960]
comp_H_in  out  512  chaining value to the compressor
comp_end  in  1  one-cycle completion pulse from the compressor
comp_H_out  in  512  updated hash from the compressor
digest_valid  out  1  one-cycle pulse when the digest is ready
digest  out  512  final hash, held until the next message completes
busy  out  1  high from the first accepted word until digest_valid

Behaviour:
- Reset: all outputs are 0, including comp_block, comp_H_in and digest. State is IDLE and all counters are cleared.
- States: IDLE, LOAD, PAD, PAD_EXTRA, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. The first accepted word loads the SHA-512 IV into comp_H_in, writes word 0, and moves to LOAD (or to PAD if in_last).
- LOAD: in_ready=1 while word_idx<16. Each handshake (in_valid & in_ready) writes word[word_idx], increments word_idx, and adds 8 (or in_bytes on the last word) to byte_cnt.
  - A full block without in_last goes to ISSUE.
  - in_last goes to PAD.
- PAD (one cycle):
  - Places 0x80 at byte offset in_bytes of the last word, or at word_idx if in_bytes=8. Zeroes the rest of the block.
  - If the 0x80 byte lands in word <=13, writes the bit length byte_cnt*8 to words 14–15 and sets final=1.
  - Otherwise sets need_extra=1.
  - A full 8-byte last word at index 15 sets pad_pending so the 0x80 byte goes into word 0 of the next block.
- PAD_EXTRA: builds the extra block: word 0 = 0x80<<56 if pad_pending, else 0; words 1..13 zero; length in words 14–15; final=1.
- in_last with in_bytes=0 (empty message) places 0x80 at byte 0 of that word.
- ISSUE: comp_start=1 for exactly one cycle, then WAIT.
- WAIT: in_ready=0. comp_block and comp_H_in stay stable from ISSUE until comp_end. On comp_end, comp_H_out is registered into comp_H_in, then:
  - non-final block: LOAD with word_idx=0;
  - need_extra: PAD_EXTRA, then ISSUE;
  - final: DONE.
- DONE: digest=comp_H_in, digest_valid=1 for one cycle, then IDLE.
- in_valid is ignored while in_ready=0. comp_end outside WAIT is ignored.
- byte_cnt wraps modulo 2^LEN_W without a flag.
- Reset asserted mid-message aborts immediately. The compressor must share the same reset.
- Latency: digest_valid follows comp_end of the final block by 2 cycles.

Optional Feature:
SHA512_T256_EN.
- Defined: adds input mode_t256 (1 bit), sampled at the first accepted word. When 1, the SHA-512/256 IV is loaded and digest[255:0] is forced to 0 (the result is in [511:256]).
- Undefined: no port, SHA-512 IV only.

Decomposition:
- Package sha512_pkg holds:
  - the state enum;
  - SHA512_IV and SHA512_T256_IV (512-bit constants);
  - BLOCK_WORDS=16 and LEN_WORD_HI=14.
- Natural sub-module: sha512_pad_word, a combinational helper that takes a word and a byte count and returns the word with 0x80 inserted and trailing bytes masked.

Test Plan:
1. "abc": one word 0x6162630000000000, in_bytes=3 -> one comp_start; digest = ddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f.
2. Empty message: in_last with in_bytes=0 -> digest = cf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e.
3. 112-byte message: 14 full words, the 14th with in_last -> 2 comp_start pulses; block 2 is all zero except length 0x380 in word 15.
4. 128-byte message: 16 full words, last word flagged -> 2 blocks; block 2 word 0 = 0x8000000000000000, length 0x400.
5. Backpressure: in_valid held high during WAIT -> in_ready=0, no word is consumed, byte_cnt is unchanged.
6. rst asserted in WAIT -> all outputs 0 in the same cycle; a following "abc" message yields the digest from scenario 1.
